// File: rtl/dispatch_arbiter_pkg.sv
// rtl/dispatch_arbiter_pkg.sv - shared opcode constants, FSM states and ROB sizing
package dispatch_arbiter_pkg;

    localparam logic [4:0] OP_NOP    = 5'b11111;
    localparam logic [4:0] OP_MEM_LO = 5'd10;
    localparam logic [4:0] OP_MEM_HI = 5'd17;

    localparam int ROB_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op >= OP_MEM_LO) && (op <= OP_MEM_HI);
    endfunction

endpackage

// File: rtl/rob_tag_alloc.sv
// rtl/rob_tag_alloc.sv - ROB tag allocation pointer and occupancy counter
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_alloc         one tag allocated this cycle
//   i_commit        one ROB entry retired this cycle
//   i_flush         clear pointer and occupancy (wins over alloc/commit)
//   o_alloc_ptr     tag handed to the next allocation
//   o_rob_count     occupied entries, 0..ROB_DEPTH
//   o_rob_full      registered, high when occupancy equals ROB_DEPTH
module rob_tag_alloc
    import dispatch_arbiter_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    input  logic             i_commit,
    input  logic             i_flush,
    output logic [TAG_W-1:0] o_alloc_ptr,
    output logic [TAG_W:0]   o_rob_count,
    output logic             o_rob_full
);

    localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    logic [TAG_W-1:0] r_alloc_ptr;
    logic [TAG_W:0]   r_rob_count;
    logic             r_rob_full;
    logic             w_commit;
    logic [TAG_W:0]   w_count_nxt;

    // A commit against an empty ROB is spurious and dropped.
    assign w_commit = i_commit && (r_rob_count != '0);

    always_comb begin
        w_count_nxt = r_rob_count;
        if (i_alloc && !w_commit) begin
            w_count_nxt = r_rob_count + CNT_ONE;
        end else if (!i_alloc && w_commit) begin
            w_count_nxt = r_rob_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alloc_ptr <= '0;
            r_rob_count <= '0;
            r_rob_full  <= 1'b0;
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_rob_count <= '0;
            r_rob_full  <= 1'b0;
        end else begin
            // Power-of-two depth: natural wrap of the pointer is the modulo.
            if (i_alloc) begin
                r_alloc_ptr <= r_alloc_ptr + TAG_ONE;
            end
            r_rob_count <= w_count_nxt;
            r_rob_full  <= (w_count_nxt == DEPTH_C);
        end
    end

    assign o_alloc_ptr = r_alloc_ptr;
    assign o_rob_count = r_rob_count;
    assign o_rob_full  = r_rob_full;

endmodule

// File: rtl/dispatch_arbiter.sv
// rtl/dispatch_arbiter.sv - steers queue head to ALU RS or LSB and allocates ROB tags
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   iq_valid, iq_op..iq_has_imm   instruction queue head
//   iq_ready                      combinational pop strobe back to the queue
//   rs_full, lsb_full             target back-pressure
//   rob_commit, flush             ROB retire, mispredict flush
//   rs_valid, lsb_valid           registered one-cycle dispatch strobes
//   disp_*                        registered dispatched fields and ROB tag
//   rob_full, rob_count           ROB occupancy
//   stall_cnt                     saturating count of cycles spent in STALL
module dispatch_arbiter
    import dispatch_arbiter_pkg::*;
#(
    parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
    parameter int TAG_W        = $clog2(ROB_DEPTH),
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iq_valid,
    input  logic [4:0]       iq_op,
    input  logic [4:0]       iq_rs1,
    input  logic [4:0]       iq_rs2,
    input  logic [4:0]       iq_rd,
    input  logic [31:0]      iq_imm,
    input  logic             iq_has_imm,
    output logic             iq_ready,
    input  logic             rs_full,
    input  logic             lsb_full,
    input  logic             rob_commit,
    input  logic             flush,
    output logic             rs_valid,
    output logic             lsb_valid,
    output logic [4:0]       disp_op,
    output logic [4:0]       disp_rs1,
    output logic [4:0]       disp_rs2,
    output logic [4:0]       disp_rd,
    output logic [31:0]      disp_imm,
    output logic             disp_has_imm,
    output logic [TAG_W-1:0] disp_tag,
    output logic             rob_full,
    output logic [TAG_W:0]   rob_count,
    output logic [15:0]      stall_cnt
);

    localparam logic [TAG_W:0] DEPTH_C   = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [7:0]     FLUSH_END = 8'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_flush_cnt;

    logic             r_rs_valid;
    logic             r_lsb_valid;
    logic [4:0]       r_disp_op;
    logic [4:0]       r_disp_rs1;
    logic [4:0]       r_disp_rs2;
    logic [4:0]       r_disp_rd;
    logic [31:0]      r_disp_imm;
    logic             r_disp_has_imm;
    logic [TAG_W-1:0] r_disp_tag;
    logic [15:0]      r_stall_cnt;

    logic             w_is_nop;
    logic             w_is_mem;
    logic             w_tgt_ready;
    logic             w_rob_space;
    logic             w_accept;
    logic             w_dispatch;
    logic [TAG_W-1:0] w_alloc_ptr;
    logic [TAG_W:0]   w_rob_count;
    logic             w_rob_full;

    assign w_is_nop    = (iq_op == OP_NOP);
    assign w_is_mem    = is_mem_op(iq_op);
    assign w_tgt_ready = w_is_mem ? !lsb_full : !rs_full;
    assign w_rob_space = (w_rob_count < DEPTH_C);

    // NOPs are popped regardless of back-pressure since they consume nothing.
    assign w_accept   = rst && !flush && (r_state != FLUSH) && iq_valid &&
                        (w_is_nop || (w_tgt_ready && w_rob_space));
    assign w_dispatch = w_accept && !w_is_nop;
    assign iq_ready   = w_accept;

    rob_tag_alloc #(
        .ROB_DEPTH (ROB_DEPTH),
        .TAG_W     (TAG_W)
    ) u_rob_tag_alloc (
        .clk         (clk),
        .rst         (rst),
        .i_alloc     (w_dispatch),
        .i_commit    (rob_commit),
        .i_flush     (flush),
        .o_alloc_ptr (w_alloc_ptr),
        .o_rob_count (w_rob_count),
        .o_rob_full  (w_rob_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Re-flushing inside FLUSH restarts the drain from zero.
            if (flush) begin
                r_flush_cnt <= '0;
            end else if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (iq_valid && !w_is_nop && !w_accept) begin
                    w_state_nxt = STALL;
                end
            end
            STALL: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FLUSH_END) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
        if (flush) begin
            w_state_nxt = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rs_valid     <= 1'b0;
            r_lsb_valid    <= 1'b0;
            r_disp_op      <= OP_NOP;
            r_disp_rs1     <= '0;
            r_disp_rs2     <= '0;
            r_disp_rd      <= '0;
            r_disp_imm     <= '0;
            r_disp_has_imm <= 1'b0;
            r_disp_tag     <= '0;
            r_stall_cnt    <= '0;
        end else begin
            r_rs_valid  <= w_dispatch && !w_is_mem;
            r_lsb_valid <= w_dispatch && w_is_mem;
            if (w_dispatch) begin
                r_disp_op      <= iq_op;
                r_disp_rs1     <= iq_rs1;
                r_disp_rs2     <= iq_rs2;
                r_disp_rd      <= iq_rd;
                r_disp_imm     <= iq_imm;
                r_disp_has_imm <= iq_has_imm;
                r_disp_tag     <= w_alloc_ptr;
            end
            // Counts the accepting STALL cycle too, so a stall of N blocked
            // cycles plus the release cycle reads N+1 minus the RUN entry cycle.
            if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign rs_valid     = r_rs_valid;
    assign lsb_valid    = r_lsb_valid;
    assign disp_op      = r_disp_op;
    assign disp_rs1     = r_disp_rs1;
    assign disp_rs2     = r_disp_rs2;
    assign disp_rd      = r_disp_rd;
    assign disp_imm     = r_disp_imm;
    assign disp_has_imm = r_disp_has_imm;
    assign disp_tag     = r_disp_tag;
    assign rob_full     = w_rob_full;
    assign rob_count    = w_rob_count;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_arbiter.sv
// tb/tb_dispatch_arbiter.sv - directed self-checking bench for dispatch_arbiter
module tb_dispatch_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iq_valid = 1'b0;
    logic [4:0]  iq_op = 5'd0;
    logic [4:0]  iq_rs1 = 5'd0;
    logic [4:0]  iq_rs2 = 5'd0;
    logic [4:0]  iq_rd = 5'd0;
    logic [31:0] iq_imm = 32'd0;
    logic        iq_has_imm = 1'b0;
    logic        iq_ready;
    logic        rs_full = 1'b0;
    logic        lsb_full = 1'b0;
    logic        rob_commit = 1'b0;
    logic        flush = 1'b0;
    logic        rs_valid;
    logic        lsb_valid;
    logic [4:0]  disp_op;
    logic [4:0]  disp_rs1;
    logic [4:0]  disp_rs2;
    logic [4:0]  disp_rd;
    logic [31:0] disp_imm;
    logic        disp_has_imm;
    logic [2:0]  disp_tag;
    logic        rob_full;
    logic [3:0]  rob_count;
    logic [15:0] stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    dispatch_arbiter #(
        .ROB_DEPTH    (8),
        .TAG_W        (3),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iq_valid     (iq_valid),
        .iq_op        (iq_op),
        .iq_rs1       (iq_rs1),
        .iq_rs2       (iq_rs2),
        .iq_rd        (iq_rd),
        .iq_imm       (iq_imm),
        .iq_has_imm   (iq_has_imm),
        .iq_ready     (iq_ready),
        .rs_full      (rs_full),
        .lsb_full     (lsb_full),
        .rob_commit   (rob_commit),
        .flush        (flush),
        .rs_valid     (rs_valid),
        .lsb_valid    (lsb_valid),
        .disp_op      (disp_op),
        .disp_rs1     (disp_rs1),
        .disp_rs2     (disp_rs2),
        .disp_rd      (disp_rd),
        .disp_imm     (disp_imm),
        .disp_has_imm (disp_has_imm),
        .disp_tag     (disp_tag),
        .rob_full     (rob_full),
        .rob_count    (rob_count),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iq_valid   = 1'b0;
        iq_op      = 5'd0;
        iq_rd      = 5'd0;
        rs_full    = 1'b0;
        lsb_full   = 1'b0;
        rob_commit = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [4:0] rd);
        iq_valid   = 1'b1;
        iq_op      = op;
        iq_rd      = rd;
        iq_rs1     = rd + 5'd1;
        iq_rs2     = rd + 5'd2;
        iq_imm     = 32'hA000_0000 + {27'd0, rd};
        iq_has_imm = rd[0];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_op(5'd1, 5'd4);
        tick();
        tick();
        n_total++; if (iq_ready !== 1'b0) $display("FAIL reset_iq_ready: got %0b exp 0", iq_ready); else n_pass++;
        n_total++; if (rs_valid !== 1'b0 || lsb_valid !== 1'b0) $display("FAIL reset_valids: got %0b%0b exp 00", rs_valid, lsb_valid); else n_pass++;
        n_total++; if (disp_op !== 5'h1F) $display("FAIL reset_disp_op: got %0h exp 1f", disp_op); else n_pass++;
        n_total++; if (disp_tag !== 3'd0 || disp_rd !== 5'd0) $display("FAIL reset_disp_fields: tag %0d rd %0d exp 0 0", disp_tag, disp_rd); else n_pass++;
        n_total++; if (rob_count !== 4'd0 || rob_full !== 1'b0 || stall_cnt !== 16'd0) $display("FAIL reset_counters: count %0d full %0b stall %0d exp 0 0 0", rob_count, rob_full, stall_cnt); else n_pass++;
        idle();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu_dispatch();
        do_reset();
        set_op(5'd1, 5'd3);
        #1;
        n_total++; if (iq_ready !== 1'b1) $display("FAIL alu_iq_ready: got %0b exp 1", iq_ready); else n_pass++;
        tick();
        idle();
        n_total++; if (rs_valid !== 1'b1 || lsb_valid !== 1'b0) $display("FAIL alu_valids: rs %0b lsb %0b exp 1 0", rs_valid, lsb_valid); else n_pass++;
        n_total++; if (disp_rd !== 5'd3 || disp_op !== 5'd1 || disp_tag !== 3'd0) $display("FAIL alu_fields: rd %0d op %0d tag %0d exp 3 1 0", disp_rd, disp_op, disp_tag); else n_pass++;
        n_total++; if (disp_rs1 !== 5'd4 || disp_rs2 !== 5'd5 || disp_imm !== 32'hA000_0003 || disp_has_imm !== 1'b1) $display("FAIL alu_operands: rs1 %0d rs2 %0d imm %0h hi %0b exp 4 5 a0000003 1", disp_rs1, disp_rs2, disp_imm, disp_has_imm); else n_pass++;
        n_total++; if (rob_count !== 4'd1) $display("FAIL alu_rob_count: got %0d exp 1", rob_count); else n_pass++;
        tick();
        n_total++; if (rs_valid !== 1'b0) $display("FAIL alu_single_pulse: got %0b exp 0", rs_valid); else n_pass++;
    endtask

    task automatic test_rob_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_op(5'd10 + 5'(i), 5'(i));
            #1;
            n_total++; if (iq_ready !== 1'b1) $display("FAIL mem_iq_ready_%0d: got %0b exp 1", i, iq_ready); else n_pass++;
            tick();
            n_total++; if (lsb_valid !== 1'b1 || rs_valid !== 1'b0 || disp_tag !== 3'(i)) $display("FAIL mem_dispatch_%0d: lsb %0b rs %0b tag %0d exp 1 0 %0d", i, lsb_valid, rs_valid, disp_tag, i); else n_pass++;
        end
        n_total++; if (rob_count !== 4'd8 || rob_full !== 1'b1) $display("FAIL rob_full_set: count %0d full %0b exp 8 1", rob_count, rob_full); else n_pass++;
        set_op(5'd12, 5'd9);
        #1;
        n_total++; if (iq_ready !== 1'b0) $display("FAIL rob_full_block: got %0b exp 0", iq_ready); else n_pass++;
        tick();
        n_total++; if (lsb_valid !== 1'b0 || stall_cnt !== 16'd0) $display("FAIL stall_entry: lsb %0b stall %0d exp 0 0", lsb_valid, stall_cnt); else n_pass++;
        tick();
        tick();
        n_total++; if (stall_cnt !== 16'd2) $display("FAIL stall_count_rob: got %0d exp 2", stall_cnt); else n_pass++;
        rob_commit = 1'b1;
        #1;
        n_total++; if (iq_ready !== 1'b0) $display("FAIL no_commit_bypass: got %0b exp 0", iq_ready); else n_pass++;
        tick();
        rob_commit = 1'b0;
        n_total++; if (rob_count !== 4'd7 || rob_full !== 1'b0 || lsb_valid !== 1'b0) $display("FAIL commit_frees: count %0d full %0b lsb %0b exp 7 0 0", rob_count, rob_full, lsb_valid); else n_pass++;
        #1;
        n_total++; if (iq_ready !== 1'b1) $display("FAIL stall_release_ready: got %0b exp 1", iq_ready); else n_pass++;
        tick();
        idle();
        n_total++; if (lsb_valid !== 1'b1 || disp_tag !== 3'd0 || disp_rd !== 5'd9) $display("FAIL wrap_tag: lsb %0b tag %0d rd %0d exp 1 0 9", lsb_valid, disp_tag, disp_rd); else n_pass++;
        n_total++; if (stall_cnt !== 16'd4 || rob_count !== 4'd8) $display("FAIL stall_release_counts: stall %0d count %0d exp 4 8", stall_cnt, rob_count); else n_pass++;
    endtask

    task automatic test_rs_full_stall();
        do_reset();
        rs_full = 1'b1;
        set_op(5'd2, 5'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++; if (rs_valid !== 1'b0 || lsb_valid !== 1'b0) $display("FAIL rs_full_hold_%0d: rs %0b lsb %0b exp 0 0", i, rs_valid, lsb_valid); else n_pass++;
        end
        rs_full = 1'b0;
        tick();
        idle();
        n_total++; if (rs_valid !== 1'b1 || lsb_valid !== 1'b0 || disp_tag !== 3'd0) $display("FAIL rs_full_dispatch: rs %0b lsb %0b tag %0d exp 1 0 0", rs_valid, lsb_valid, disp_tag); else n_pass++;
        n_total++; if (stall_cnt !== 16'd5) $display("FAIL rs_full_stall_cnt: got %0d exp 5", stall_cnt); else n_pass++;
        tick();
        n_total++; if (stall_cnt !== 16'd5 || lsb_valid !== 1'b0) $display("FAIL stall_cnt_frozen: stall %0d lsb %0b exp 5 0", stall_cnt, lsb_valid); else n_pass++;
    endtask

    task automatic test_flush();
        logic [4:0] ops [4];
        ops[0] = 5'd9; ops[1] = 5'd18; ops[2] = 5'd3; ops[3] = 5'd4;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_op(ops[i], 5'(i + 1));
            tick();
            n_total++; if (rs_valid !== 1'b1 || lsb_valid !== 1'b0) $display("FAIL alu_class_%0d: rs %0b lsb %0b exp 1 0", i, rs_valid, lsb_valid); else n_pass++;
        end
        n_total++; if (rob_count !== 4'd4) $display("FAIL pre_flush_count: got %0d exp 4", rob_count); else n_pass++;
        set_op(5'd4, 5'd20);
        flush = 1'b1;
        rob_commit = 1'b1;
        #1;
        n_total++; if (iq_ready !== 1'b0) $display("FAIL flush_cycle_ready: got %0b exp 0", iq_ready); else n_pass++;
        tick();
        flush = 1'b0;
        rob_commit = 1'b0;
        n_total++; if (rs_valid !== 1'b0 || lsb_valid !== 1'b0 || rob_count !== 4'd0) $display("FAIL flush_clear: rs %0b lsb %0b count %0d exp 0 0 0", rs_valid, lsb_valid, rob_count); else n_pass++;
        n_total++; if (iq_ready !== 1'b0) $display("FAIL flush_state_ready_1: got %0b exp 0", iq_ready); else n_pass++;
        tick();
        n_total++; if (iq_ready !== 1'b0) $display("FAIL flush_state_ready_2: got %0b exp 0", iq_ready); else n_pass++;
        tick();
        n_total++; if (iq_ready !== 1'b1) $display("FAIL flush_resume_ready: got %0b exp 1", iq_ready); else n_pass++;
        tick();
        idle();
        n_total++; if (rs_valid !== 1'b1 || disp_tag !== 3'd0 || disp_rd !== 5'd20 || rob_count !== 4'd1) $display("FAIL post_flush_dispatch: rs %0b tag %0d rd %0d count %0d exp 1 0 20 1", rs_valid, disp_tag, disp_rd, rob_count); else n_pass++;
    endtask

    task automatic test_nop();
        do_reset();
        set_op(5'd1, 5'd6);
        tick();
        rs_full  = 1'b1;
        lsb_full = 1'b1;
        set_op(5'h1F, 5'd7);
        #1;
        n_total++; if (iq_ready !== 1'b1) $display("FAIL nop_ready: got %0b exp 1", iq_ready); else n_pass++;
        tick();
        n_total++; if (rs_valid !== 1'b0 || lsb_valid !== 1'b0 || rob_count !== 4'd1) $display("FAIL nop_no_dispatch: rs %0b lsb %0b count %0d exp 0 0 1", rs_valid, lsb_valid, rob_count); else n_pass++;
        n_total++; if (disp_rd !== 5'd6 || stall_cnt !== 16'd0) $display("FAIL nop_fields_hold: rd %0d stall %0d exp 6 0", disp_rd, stall_cnt); else n_pass++;
        rs_full  = 1'b0;
        lsb_full = 1'b0;
        set_op(5'd1, 5'd8);
        tick();
        idle();
        n_total++; if (rs_valid !== 1'b1 || disp_tag !== 3'd1) $display("FAIL nop_no_tag: rs %0b tag %0d exp 1 1", rs_valid, disp_tag); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_op(5'd3, 5'(i + 1));
            tick();
        end
        rs_full = 1'b1;
        set_op(5'd5, 5'd11);
        tick();
        tick();
        n_total++; if (rob_count !== 4'd6 || stall_cnt !== 16'd1) $display("FAIL mid_stall_setup: count %0d stall %0d exp 6 1", rob_count, stall_cnt); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (iq_ready !== 1'b0) $display("FAIL rst_low_ready: got %0b exp 0", iq_ready); else n_pass++;
        tick();
        n_total++; if (rs_valid !== 1'b0 || lsb_valid !== 1'b0 || disp_op !== 5'h1F || disp_rd !== 5'd0 || disp_tag !== 3'd0) $display("FAIL mid_stall_reset_disp: rs %0b lsb %0b op %0h rd %0d tag %0d exp 0 0 1f 0 0", rs_valid, lsb_valid, disp_op, disp_rd, disp_tag); else n_pass++;
        n_total++; if (rob_count !== 4'd0 || rob_full !== 1'b0 || stall_cnt !== 16'd0) $display("FAIL mid_stall_reset_cnt: count %0d full %0b stall %0d exp 0 0 0", rob_count, rob_full, stall_cnt); else n_pass++;
        rst = 1'b1;
        rs_full = 1'b0;
        #1;
        n_total++; if (iq_ready !== 1'b1) $display("FAIL post_rst_ready: got %0b exp 1", iq_ready); else n_pass++;
        tick();
        idle();
        n_total++; if (rs_valid !== 1'b1 || disp_tag !== 3'd0 || disp_rd !== 5'd11 || disp_op !== 5'd5) $display("FAIL post_rst_dispatch: rs %0b tag %0d rd %0d op %0d exp 1 0 11 5", rs_valid, disp_tag, disp_rd, disp_op); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_dispatch();
        test_rob_full();
        test_rs_full_stall();
        test_flush();
        test_nop();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
